mem_bus_sched: RTL and testbench
================================

// Module: mem_bus_sched
// PURPOSE
//  Sequences the single byte-wide memory/UART bus and shares it between two requesters:
//  instruction fetch (IF, always 32-bit reads) and load/store (LS, 1/2/4-byte reads/writes).
//  Each granted word access is split into byte beats, and read bytes are assembled little-endian.
//  Sits between the cache/commit logic and the external bus pins of the cpu top.
// PARAMETERS
//  IO_HI_BITS  2'b11  value of addr[17:16] marking the memory-mapped I/O region
// PORTS
//  clk             in   1   system clock
//  rst             in   1   asynchronous active-high reset
//  rdy             in   1   global enable; low freezes all state
//  mem_din         in   8   byte returned from bus (valid cycle after read address)
//  mem_dout        out  8   write byte
//  mem_a           out  32  bus address
//  mem_wr          out  1   1=write, 0=read
//  io_buffer_full  in   1   UART tx buffer full
//  clr             in   1   pipeline flush (mispredict)
//  if_req          in   1   IF read request (level, held until if_ack)
//  if_addr         in   32  IF word address
//  if_ack          out  1   one-cycle pulse: if_data valid
//  if_data         out  32  fetched instruction
//  ls_req          in   1   LS request (level, held until ls_ack)
//  ls_we           in   1   1=store, 0=load
//  ls_size         in   2   0=byte,1=half,2=word (3 treated as word)
//  ls_addr         in   32  LS byte address
//  ls_wdata        in   32  store data, low bytes used
//  ls_ack          out  1   one-cycle pulse: op done / ls_rdata valid
//  ls_rdata        out  32  load data, zero-extended (LS sign-extends)
// BEHAVIOUR
//  - Reset: state IDLE, mem_a=0, mem_dout=0, mem_wr=0, if_ack=0, ls_ack=0, if_data=0, ls_rdata=0.
//  - FSM: IDLE -> RD (read grant) | WR (store grant); RD/WR -> IDLE after last beat; WR <-> IO_WAIT.
//  - IDLE arbitration (default): LS beats IF when both request; grant taken on the edge req seen.
//  - Beats: N = 1/2/4 bytes; beat i drives mem_a = base+i. Reads: byte i sampled from mem_din
//    one cycle later into bits [8i+7:8i]; ack at cycle N+1 after grant (word read: 5 cycles).
//  - Writes: mem_wr=1, mem_dout=wdata[8i+7:8i] for beats 0..N-1; ls_ack pulses the cycle after last beat.
//  - I/O write (addr[17:16]==IO_HI_BITS, ls_we=1): before each beat, if io_buffer_full=1, enter
//    IO_WAIT with mem_wr=0 and mem_a held; resume beat when io_buffer_full=0. I/O reads unaffected.
//  - mem_wr is 0 in IDLE, RD and IO_WAIT; no read address is issued during a write op.
//  - Back-to-back: new grant may start in the cycle ack pulses (no idle bubble required).
//  - clr: an in-flight IF read aborts at the next edge (no if_ack, state->IDLE); if_req sampled in
//    the clr cycle is ignored. LS ops are never aborted by clr (committed stores must finish).
//  - rdy=0: state, counters, and assembled data hold; mem_wr forced 0; acks held off; resume exact.
//  - Address increment is 32-bit wrap-around; unaligned LS addresses are legal (byte-serial).
//  - Reset mid-operation: asynchronous return to IDLE; partial data discarded, no ack.
// CONFIGURATION
//  MEM_BUS_RR_EN: defined -> round-robin between IF and LS; last-granted requester loses a tie.
//    Tie state resets to "IF last" (first tie goes to LS).
//  undefined -> fixed priority LS > IF (IF may starve while LS requests continuously).
// TESTING
//  1. if_req, if_addr=0x100, mem=13 05 00 00 -> if_ack at cycle 5, if_data=0x00000513.
//  2. ls store word 0xDEADBEEF @0x200 -> mem_wr=1, bytes EF,BE,AD,DE at 0x200..0x203; ls_ack cycle 4.
//  3. ls_req+if_req same cycle, no RR -> LS served first; IF grant in LS-ack cycle; both acks seen.
//  4. store byte 0x41 @0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for 3 cycles, then one write.
//  5. clr at cycle 2 of IF read -> no if_ack, bus idle next cycle; concurrent LS store still completes.
//  6. rdy low 4 cycles mid load-half 0x1234 -> no beat advance, ls_rdata=0x00001234 after resume.

Source files
------------

// File: rtl/mem_bus_sched.sv
// Byte-serial memory/UART bus sequencer shared by instruction fetch (IF) and load/store (LS).
// Define MEM_BUS_RR_EN for round-robin arbitration; otherwise LS has fixed priority over IF.
module mem_bus_sched #(
    parameter logic [1:0] IO_HI_BITS = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        clr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata
);
    // state   | meaning
    // IDLE    | bus free, arbitrating requests
    // RD      | issuing read addresses and collecting bytes
    // WR      | driving store beats
    // IO_WAIT | I/O store stalled on a full UART buffer
    typedef enum logic [1:0] {IDLE, RD, WR, IO_WAIT} state_t;

    state_t      state;
    logic [2:0]  k, n, k_inc, n_req;
    logic [1:0]  k_idx, k_prev;
    logic [31:0] base, wdata, data_q, data_nxt;
    logic        owner_ls, is_io, wr_q, if_ack_q, ls_ack_q;
    logic        ls_io, if_ok, grant_ls, grant_if;
    logic [7:0]  wbyte_cur, wbyte_next;

    assign k_inc  = k + 3'd1;
    assign k_idx  = k[1:0];
    assign k_prev = k_idx - 2'd1;
    assign n_req  = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
    assign ls_io  = (ls_addr[17:16] == IO_HI_BITS);
    assign if_ok  = if_req && !clr;

`ifdef MEM_BUS_RR_EN
    logic last_if;
    assign grant_ls = ls_req && (!if_ok || last_if);
`else
    assign grant_ls = ls_req;
`endif
    assign grant_if = if_ok && !grant_ls;

    assign wbyte_cur  = wdata[{k_idx, 3'b000} +: 8];
    assign wbyte_next = wdata[{k_idx + 2'd1, 3'b000} +: 8];

    // k counts edges since grant; read byte k-1 arrives on mem_din at edge k
    always_comb begin
        data_nxt = data_q;
        data_nxt[{k_prev, 3'b000} +: 8] = mem_din;
    end

    assign mem_wr = wr_q & rdy;
    assign if_ack = if_ack_q & rdy;
    assign ls_ack = ls_ack_q & rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            k        <= 3'd0;
            n        <= 3'd0;
            base     <= 32'd0;
            wdata    <= 32'd0;
            data_q   <= 32'd0;
            owner_ls <= 1'b0;
            is_io    <= 1'b0;
            wr_q     <= 1'b0;
            if_ack_q <= 1'b0;
            ls_ack_q <= 1'b0;
            mem_a    <= 32'd0;
            mem_dout <= 8'd0;
            if_data  <= 32'd0;
            ls_rdata <= 32'd0;
`ifdef MEM_BUS_RR_EN
            last_if  <= 1'b1;
`endif
        end else if (rdy) begin
            if_ack_q <= 1'b0;
            ls_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ls) begin
                        base     <= ls_addr;
                        n        <= n_req;
                        owner_ls <= 1'b1;
                        is_io    <= ls_io;
                        wdata    <= ls_wdata;
                        k        <= 3'd0;
                        data_q   <= 32'd0;
                        mem_a    <= ls_addr;
                        mem_dout <= ls_wdata[7:0];
`ifdef MEM_BUS_RR_EN
                        last_if  <= 1'b0;
`endif
                        if (!ls_we) begin
                            state <= RD;
                        end else if (ls_io && io_buffer_full) begin
                            state <= IO_WAIT;
                            wr_q  <= 1'b0;
                        end else begin
                            state <= WR;
                            wr_q  <= 1'b1;
                        end
                    end else if (grant_if) begin
                        base     <= if_addr;
                        n        <= 3'd4;
                        owner_ls <= 1'b0;
                        is_io    <= 1'b0;
                        k        <= 3'd0;
                        data_q   <= 32'd0;
                        mem_a    <= if_addr;
                        state    <= RD;
`ifdef MEM_BUS_RR_EN
                        last_if  <= 1'b1;
`endif
                    end
                end
                RD: begin
                    if (clr && !owner_ls) begin
                        state <= IDLE;
                    end else begin
                        if (k_inc < n)
                            mem_a <= base + {29'd0, k_inc};
                        if (k != 3'd0)
                            data_q <= data_nxt;
                        k <= k_inc;
                        if (k == n) begin
                            state <= IDLE;
                            if (owner_ls) begin
                                ls_ack_q <= 1'b1;
                                ls_rdata <= data_nxt;
                            end else begin
                                if_ack_q <= 1'b1;
                                if_data  <= data_nxt;
                            end
                        end
                    end
                end
                WR: begin
                    if (k_inc < n) begin
                        k <= k_inc;
                        if (is_io && io_buffer_full) begin
                            state <= IO_WAIT;
                            wr_q  <= 1'b0;
                        end else begin
                            mem_a    <= base + {29'd0, k_inc};
                            mem_dout <= wbyte_next;
                        end
                    end else begin
                        wr_q     <= 1'b0;
                        ls_ack_q <= 1'b1;
                        state    <= IDLE;
                    end
                end
                IO_WAIT: begin
                    // address stays on the previous beat until the buffer drains
                    if (!io_buffer_full) begin
                        state    <= WR;
                        wr_q     <= 1'b1;
                        mem_a    <= base + {29'd0, k};
                        mem_dout <= wbyte_cur;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_sched.sv
// Self-checking bench for mem_bus_sched: directed scenarios plus randomized ops against
// a byte-array reference memory. Cycle k below means the cycle after the k-th edge past the grant.
module tb_mem_bus_sched;
    logic        clk = 1'b0;
    logic        rst, rdy, mem_wr, io_buffer_full, clr;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        if_req, if_ack, ls_req, ls_we, ls_ack;
    logic [31:0] if_addr, if_data, ls_addr, ls_wdata, ls_rdata;
    logic [1:0]  ls_size;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0]  mem [4096];
    logic [7:0]  ref_mem [4096];
    logic [39:0] io_q [$];

    always #5 clk = ~clk;

    mem_bus_sched dut (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .clr(clr),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata)
    );

    function automatic logic [7:0] pat(int i);
        return 8'(i * 29 + 7);
    endfunction

    // Bus-side memory: registered read, one cycle latency; the whole system freezes with rdy.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
            mem_din <= 8'd0;
        end else if (rdy) begin
            if (mem_wr) begin
                if (mem_a[17:16] == 2'b11) io_q.push_back({mem_a, mem_dout});
                else mem[mem_a[11:0]] <= mem_dout;
            end
            mem_din <= mem[mem_a[11:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] a, int n);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = ref_mem[12'(a + 32'(i))];
        return r;
    endfunction

    function automatic logic [31:0] bus_mem(logic [31:0] a, int n);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = mem[12'(a + 32'(i))];
        return r;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
        logic [31:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            if (ai[17:16] != 2'b11) ref_mem[ai[11:0]] = d[8*i +: 8];
        end
    endtask

    // Issue one request and wait for its ack; optional rdy stall and io_buffer_full window.
    task automatic run_op(input bit is_if, input bit we, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int st_at, input int st_len, input int full_len,
                          output int cyc, output logic [31:0] rd, output int wr_cnt);
        bit done = 0;
        int stray = 0;
        cyc = -1; rd = 32'd0; wr_cnt = 0;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = addr; ls_wdata = wd;
        end
        io_buffer_full = (full_len > 0);
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mem_wr) wr_cnt++;
            if (is_if ? ls_ack : if_ack) stray++;
            if (is_if ? if_ack : ls_ack) begin
                done = 1;
                rd = is_if ? if_data : ls_rdata;
                if_req = 1'b0; ls_req = 1'b0;
            end
            if (cyc == full_len - 1) io_buffer_full = 1'b0;
            if (cyc == st_at && st_len > 0) rdy = 1'b0;
            if (cyc == st_at + st_len) rdy = 1'b1;
        end
        rdy = 1'b1; io_buffer_full = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        chk("op_done", 32'(done), 32'd1);
        chk("stray_ack", 32'(stray), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, wrc, n, lat, st_at, st_len, ls_cyc, if_cyc, wr_cyc, got_if;
        logic [31:0] rd, ls_d, if_d, addr, wd;
        logic [39:0] io_e;
        logic [1:0] sz;
        bit is_if, we;

        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; ls_req = 1'b0; ls_we = 1'b0;
        ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
        repeat (4) @(negedge clk);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_acks", {30'd0, if_ack, ls_ack}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // simultaneous requests: LS first, IF granted in the LS ack cycle
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h80;
        cyc = -1; ls_cyc = -1; if_cyc = -1; ls_d = 0; if_d = 0;
        while ((ls_cyc < 0 || if_cyc < 0) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ls_ack && ls_cyc < 0) begin ls_cyc = cyc; ls_d = ls_rdata; ls_req = 1'b0; end
            if (if_ack && if_cyc < 0) begin if_cyc = cyc; if_d = if_data; if_req = 1'b0; end
        end
        if_req = 1'b0; ls_req = 1'b0;
        chk("tie_ls_cyc", 32'(ls_cyc), 32'd5);
        chk("tie_if_cyc", 32'(if_cyc), 32'd11);
        chk("tie_ls_data", ls_d, ref_load(32'h40, 4));
        chk("tie_if_data", if_d, ref_load(32'h80, 4));
        @(negedge clk);

        // store word, then fetch it back through IF
        run_op(0, 1, 2'd2, 32'h200, 32'hDEADBEEF, -5, 0, 0, cyc, rd, wrc);
        ref_store(32'h200, 4, 32'hDEADBEEF);
        chk("sw_cyc", 32'(cyc), 32'd4);
        chk("sw_beats", 32'(wrc), 32'd4);
        chk("sw_mem", bus_mem(32'h200, 4), 32'hDEADBEEF);
        @(negedge clk);
        run_op(0, 1, 2'd2, 32'h100, 32'h00000513, -5, 0, 0, cyc, rd, wrc);
        ref_store(32'h100, 4, 32'h00000513);
        @(negedge clk);
        run_op(1, 0, 2'd2, 32'h100, 32'h0, -5, 0, 0, cyc, rd, wrc);
        chk("if_cyc", 32'(cyc), 32'd5);
        chk("if_data", rd, 32'h00000513);
        @(negedge clk);

        // I/O byte store held off by a full UART buffer for three cycles
        io_q.delete();
        run_op(0, 1, 2'd0, 32'h30000, 32'h41, -5, 0, 3, cyc, rd, wrc);
        chk("io_cyc", 32'(cyc), 32'd4);
        chk("io_beats", 32'(wrc), 32'd1);
        chk("io_cnt", 32'(io_q.size()), 32'd1);
        io_e = (io_q.size() > 0) ? io_q[0] : 40'd0;
        chk("io_addr", io_e[39:8], 32'h30000);
        chk("io_byte", 32'(io_e[7:0]), 32'h41);
        @(negedge clk);

        // clr aborts an IF read; an LS store raised in the clr cycle still completes
        if_req = 1'b1; if_addr = 32'h100;
        cyc = -1; got_if = 0; ls_cyc = -1; wr_cyc = -1;
        while (cyc < 15) begin
            @(negedge clk);
            cyc++;
            if (if_ack) got_if++;
            if (mem_wr && wr_cyc < 0) wr_cyc = cyc;
            if (ls_ack && ls_cyc < 0) begin ls_cyc = cyc; ls_req = 1'b0; end
            if (cyc == 2) begin
                clr = 1'b1; if_req = 1'b0;
                ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h210; ls_wdata = 32'h5A;
            end
            if (cyc == 3) clr = 1'b0;
        end
        ls_req = 1'b0;
        ref_store(32'h210, 1, 32'h5A);
        chk("clr_if_ack", 32'(got_if), 32'd0);
        chk("clr_wr_cyc", 32'(wr_cyc), 32'd4);
        chk("clr_ls_cyc", 32'(ls_cyc), 32'd5);
        chk("clr_mem", bus_mem(32'h210, 1), 32'h5A);
        @(negedge clk);

        // rdy low for four cycles in the middle of a half-word load
        run_op(0, 1, 2'd1, 32'h300, 32'hFFFF1234, -5, 0, 0, cyc, rd, wrc);
        ref_store(32'h300, 2, 32'hFFFF1234);
        @(negedge clk);
        run_op(0, 0, 2'd1, 32'h300, 32'h0, 1, 4, 0, cyc, rd, wrc);
        chk("rdy_cyc", 32'(cyc), 32'd7);
        chk("rdy_data", rd, 32'h00001234);
        @(negedge clk);

        // address wrap-around on a word load
        run_op(0, 0, 2'd2, 32'hFFFFFFFE, 32'h0, -5, 0, 0, cyc, rd, wrc);
        chk("wrap_cyc", 32'(cyc), 32'd5);
        chk("wrap_data", rd, ref_load(32'hFFFFFFFE, 4));
        @(negedge clk);

        for (int t = 0; t < 60; t++) begin
            is_if  = ($urandom_range(0, 2) == 0);
            we     = is_if ? 1'b0 : 1'($urandom_range(0, 1));
            sz     = 2'($urandom_range(0, 3));
            addr   = $urandom & 32'hFFFC_FFFF;
            wd     = $urandom;
            n      = is_if ? 4 : nbytes(sz);
            lat    = we ? n : n + 1;
            st_len = $urandom_range(0, 3);
            st_at  = $urandom_range(0, lat - 1);
            run_op(is_if, we, sz, addr, wd, st_at, st_len, 0, cyc, rd, wrc);
            chk("rnd_cyc", 32'(cyc), 32'(lat + st_len));
            chk("rnd_beats", 32'(wrc), we ? 32'(n) : 32'd0);
            if (we) begin
                ref_store(addr, n, wd);
                chk("rnd_store", bus_mem(addr, n), ref_load(addr, n));
            end else begin
                chk("rnd_load", rd, ref_load(addr, n));
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
